// File: rtl/serial_word_pkg.sv
// Shared types for the serial word link (rx state encoding, counter sizing).
// Used by both the transmitter and receiver blocks.
package serial_word_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2
  } rx_state_e;

  // Bits needed to hold a counter ranging over 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/serial_word_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is always visible on rdata.
// A push while full is accepted only when a pop happens in the same cycle.
module serial_word_fifo #(
  parameter int DATA_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  wr_ok, rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign rdata = mem[rd_ptr];

  assign wr_ok = push & (~full | pop);
  assign rd_ok = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/serial_word_rx.sv
// Serial word receiver: rebuilds LSB-first words from ser_data/ser_en and queues them in a FWFT FIFO.
// Optional even-parity bit per word when SERIAL_RX_PARITY_EN is defined (adds parity_err port).
module serial_word_rx
  import serial_word_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int GAP_MAX    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ser_data,
  input  logic                    ser_en,
  output logic [DATA_WIDTH-1:0]   word_out,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic                    overrun,
`ifdef SERIAL_RX_PARITY_EN
  output logic                    parity_err,
`endif
  output logic                    frame_err
);

  localparam int BCW = cnt_w(DATA_WIDTH - 1);
  localparam int GCW = cnt_w(GAP_MAX);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_MAX - 1);

  rx_state_e             state, state_d;
  logic [BCW-1:0]        bit_cnt, bit_cnt_d;
  logic [GCW-1:0]        gap_cnt, gap_cnt_d;
  logic [DATA_WIDTH-1:0] shreg, shreg_d;
  logic                  push_q, push_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q;
  logic                  fifo_full, fifo_empty, pop;
`ifdef SERIAL_RX_PARITY_EN
  logic                  parity_err_q, parity_err_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    gap_cnt_d   = gap_cnt;
    shreg_d     = shreg;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    parity_err_d = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        gap_cnt_d = '0;
        if (ser_en) begin
          shreg_d[0] = ser_data;
          bit_cnt_d  = BCW'(1);
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (ser_en) begin
          shreg_d[bit_cnt] = ser_data;
          gap_cnt_d        = '0;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef SERIAL_RX_PARITY_EN
            state_d   = S_PAR;
`else
            state_d   = S_IDLE;
            push_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end else if (gap_cnt == GAP_LAST) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
          bit_cnt_d   = '0;
          gap_cnt_d   = '0;
          shreg_d     = '0;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      S_PAR: begin
        if (ser_en) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
          // Even parity: data ones plus parity bit must be even.
          if (ser_data == ^shreg) push_d       = 1'b1;
          else                    parity_err_d = 1'b1;
        end else if (gap_cnt == GAP_LAST) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
          gap_cnt_d   = '0;
          shreg_d     = '0;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // shreg doubles as the commit buffer: the FIFO captures it on the edge
  // where a following word may already be loading bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      shreg       <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      bit_cnt     <= bit_cnt_d;
      gap_cnt     <= gap_cnt_d;
      shreg       <= shreg_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= push_q & fifo_full & ~pop;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end
  assign parity_err = parity_err_q;
`endif

  assign pop        = word_valid & word_ready;
  assign word_valid = ~fifo_empty;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

  serial_word_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .wdata (shreg),
    .pop   (pop),
    .rdata (word_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fill_level)
  );

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx (DATA_WIDTH=5, DEPTH=4, GAP_MAX=8).
// Parity cases run only when SERIAL_RX_PARITY_EN is defined.
module tb_serial_word_rx;

  localparam int DW = 5;
  localparam int DP = 4;
  localparam int GM = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ser_data, ser_en, word_ready;
  logic [DW-1:0] word_out;
  logic          word_valid, overrun, frame_err;
  logic [2:0]    fill_level;
`ifdef SERIAL_RX_PARITY_EN
  logic          parity_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_word_rx #(.DATA_WIDTH(DW), .DEPTH(DP), .GAP_MAX(GM)) dut (
    .clk        (clk),
    .rst        (rst),
    .ser_data   (ser_data),
    .ser_en     (ser_en),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .fill_level (fill_level),
    .overrun    (overrun),
`ifdef SERIAL_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .frame_err  (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks happen in that window too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) begin
      ser_en   = 1'b1;
      ser_data = w[i];
      tick();
    end
    ser_en   = 1'b0;
    ser_data = 1'b0;
  endtask

  task automatic drain(input string tag, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                       input logic [DW-1:0] w2, input logic [DW-1:0] w3, input int n);
    logic [DW-1:0] exp_w [4];
    exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
    word_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      check({tag, "_vld"}, word_valid, 1'b1);
      check({tag, "_word"}, word_out, exp_w[k]);
      tick();
    end
    word_ready = 1'b0;
    check({tag, "_empty"}, word_valid, 1'b0);
    check({tag, "_lvl0"}, fill_level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ser_data = 1'b0; ser_en = 1'b0; word_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_vld", word_valid, 1'b0);
    check("rst_lvl", fill_level, 0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_ferr", frame_err, 1'b0);

    // 1: bits 1,0,1,1,0 -> 5'b01101, valid two cycles after the last bit
    send_word(5'b01101);
    check("t1_lat1", word_valid, 1'b0);
    tick();
    check("t1_vld", word_valid, 1'b1);
    check("t1_word", word_out, 5'b01101);
    check("t1_lvl", fill_level, 1);
    drain("t1", 5'b01101, 5'b0, 5'b0, 5'b0, 1);

    // 2: five words with no consumer -> overrun on the fifth, head still word 1
    send_word(5'h11); send_word(5'h02); send_word(5'h1c); send_word(5'h07);
    tick();
    check("t2_lvl4", fill_level, 4);
    check("t2_head", word_out, 5'h11);
    send_word(5'h15);
    check("t2_ovr_pre", overrun, 1'b0);
    tick();
    check("t2_ovr", overrun, 1'b1);
    check("t2_lvl", fill_level, 4);
    check("t2_head2", word_out, 5'h11);
    tick();
    check("t2_ovr_end", overrun, 1'b0);
    drain("t2", 5'h11, 5'h02, 5'h1c, 5'h07, 4);

    // 3: 3 bits then an 8-cycle gap -> frame_err, then a clean word
    for (int i = 0; i < 3; i++) begin
      ser_en = 1'b1; ser_data = 1'b1; tick();
    end
    ser_en = 1'b0; ser_data = 1'b0;
    for (int i = 0; i < GM - 1; i++) tick();
    check("t3_ferr_early", frame_err, 1'b0);
    tick();
    check("t3_ferr", frame_err, 1'b1);
    tick();
    check("t3_ferr_end", frame_err, 1'b0);
    check("t3_nocommit", word_valid, 1'b0);
    send_word(5'b10010);
    tick();
    check("t3_vld", word_valid, 1'b1);
    drain("t3", 5'b10010, 5'b0, 5'b0, 5'b0, 1);

    // 4: full FIFO, pop in the commit cycle -> no overrun, order kept
    send_word(5'h01); send_word(5'h1e); send_word(5'h0a); send_word(5'h13);
    tick();
    check("t4_lvl4", fill_level, 4);
    send_word(5'h0c);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check("t4_ovr", overrun, 1'b0);
    check("t4_lvl", fill_level, 4);
    tick();
    check("t4_ovr2", overrun, 1'b0);
    drain("t4", 5'h1e, 5'h0a, 5'h13, 5'h0c, 4);

    // 5: reset with 2 words buffered and 2 bits of a third in flight
    send_word(5'h09); send_word(5'h16);
    tick();
    check("t5_lvl2", fill_level, 2);
    ser_en = 1'b1; ser_data = 1'b1; tick();
    ser_data = 1'b0; tick();
    ser_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_vld", word_valid, 1'b0);
    check("t5_lvl", fill_level, 0);
    check("t5_ovr", overrun, 1'b0);
    check("t5_ferr", frame_err, 1'b0);
    tick();
    check("t5_ovr2", overrun, 1'b0);
    check("t5_ferr2", frame_err, 1'b0);
    send_word(5'b00110);
    tick();
    check("t5_post_vld", word_valid, 1'b1);
    drain("t5", 5'b00110, 5'b0, 5'b0, 5'b0, 1);

`ifdef SERIAL_RX_PARITY_EN
    // 6: bits 1,1,0,0,0 with wrong then right parity
    send_word(5'b00011);
    ser_en = 1'b1; ser_data = 1'b1; tick(); ser_en = 1'b0; ser_data = 1'b0;
    check("t6_perr", parity_err, 1'b1);
    tick();
    check("t6_perr_end", parity_err, 1'b0);
    check("t6_nocommit", word_valid, 1'b0);
    send_word(5'b00011);
    ser_en = 1'b1; ser_data = 1'b0; tick(); ser_en = 1'b0;
    check("t6_perr_ok", parity_err, 1'b0);
    tick();
    check("t6_vld", word_valid, 1'b1);
    drain("t6", 5'b00011, 5'b0, 5'b0, 5'b0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
